// File: rtl/id_disp_pkg.sv
// Shared types and the seven-segment decoder for the ID scroller.
// Segments are active-low, packed as {g,f,e,d,c,b,a}.
package id_disp_pkg;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_BLANK = 7'h7F;

  typedef enum logic {SHOW, GAP} disp_state_t;

  // 0-9, A-E as hex letters; F is the blank glyph so IDs can pad with F.
  function automatic seg7_t hex_to_seg(input logic [3:0] d);
    case (d)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/step_divider.sv
// Scroll-step divider: one-cycle tick every DIV running cycles.
// run=0 freezes the count; reset_div=0 clears it and suppresses the tick.
module step_divider #(
  parameter int DIV = 4
) (
  input  logic clk_50M,
  input  logic reset,
  input  logic reset_div,
  input  logic run,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = reset_div && run && (cnt == LAST);

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (!reset_div || tick) cnt <= '0;
    else if (run)               cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/id_scroller.sv
// Scrolls a NUM_DIGITS-digit ID across NUM_HEX seven-segment displays.
// Optional macro ID_BLINK_EN inserts a blank GAP step after each wrap.
module id_scroller
  import id_disp_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int STEP_HZ    = 2,
  parameter int NUM_DIGITS = 7,
  parameter int NUM_HEX    = 6,
  parameter logic [4*NUM_DIGITS-1:0] ID = 28'h7654321,
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                 clk_50M,
  input  logic                 reset,
  input  logic                 reset_div,
  input  logic                 run,
  output logic [7*NUM_HEX-1:0] hex_out,
  output logic [PW-1:0]        pos,
  output logic                 wrap
);
  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int W1  = PW + 1;
  localparam int NSL = 2 ** PW;
  localparam logic [PW-1:0] POS_LAST = PW'(NUM_DIGITS - 1);

  logic tick, blank, last;
  logic [PW-1:0] pos_r, pos_nx;
  logic wrap_r, wrap_nx;
  seg7_t [NUM_HEX-1:0] hex_r, hex_nx;
  logic [3:0] digits [NSL];

  step_divider #(.DIV(DIV)) u_div (
    .clk_50M  (clk_50M),
    .reset    (reset),
    .reset_div(reset_div),
    .run      (run),
    .tick     (tick)
  );

  assign last = (pos_r == POS_LAST);

  // Unused slots of the power-of-two table read as blank; they are never selected.
  for (genvar i = 0; i < NSL; i++) begin : g_dig
    if (i < NUM_DIGITS) begin : g_id
      assign digits[i] = ID[4*i +: 4];
    end else begin : g_pad
      assign digits[i] = 4'hF;
    end
  end

`ifdef ID_BLINK_EN
  disp_state_t state, state_nx;

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) state <= SHOW;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pos_nx   = pos_r;
    wrap_nx  = 1'b0;
    if (tick) begin
      case (state)
        SHOW: if (last) begin
          state_nx = GAP;
          pos_nx   = '0;
          wrap_nx  = 1'b1;
        end else begin
          pos_nx = pos_r + 1'b1;
        end
        GAP: state_nx = SHOW;  // leave the gap on window 0, no increment
        default: state_nx = SHOW;
      endcase
    end
  end

  assign blank = (state == GAP);
`else
  always_comb begin
    pos_nx  = pos_r;
    wrap_nx = 1'b0;
    if (tick) begin
      if (last) begin
        pos_nx  = '0;
        wrap_nx = 1'b1;
      end else begin
        pos_nx = pos_r + 1'b1;
      end
    end
  end

  assign blank = 1'b0;
`endif

  // HEX k shows digit (pos + NUM_HEX-1-k) mod NUM_DIGITS; one conditional subtract suffices.
  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
    localparam int OFF = (NUM_HEX - 1 - k) % NUM_DIGITS;
    logic [W1-1:0] sum;
    logic [PW-1:0] idx;
    assign sum = {1'b0, pos_r} + W1'(OFF);
    assign idx = (sum >= W1'(NUM_DIGITS)) ? PW'(sum - W1'(NUM_DIGITS)) : sum[PW-1:0];
    assign hex_nx[k] = blank ? SEG_BLANK : hex_to_seg(digits[idx]);
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      pos_r  <= '0;
      wrap_r <= 1'b0;
      hex_r  <= {NUM_HEX{SEG_BLANK}};
    end else begin
      pos_r  <= pos_nx;
      wrap_r <= wrap_nx;
      hex_r  <= hex_nx;
    end
  end

  assign pos     = pos_r;
  assign wrap    = wrap_r;
  assign hex_out = hex_r;
endmodule

// File: tb/tb_id_scroller.sv
// Random-stimulus bench for id_scroller (DIV=4, 7 digits, 6 displays) against a
// behavioural model, plus hand-computed window/position checkpoints.
module tb_id_scroller;
  localparam int ND  = 7;
  localparam int NH  = 6;
  localparam int DIV = 4;
  localparam logic [27:0] ID_V = 28'h7654321;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

  // Hand-computed windows, HEX5..HEX0
  localparam logic [41:0] W0 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};  // 1 2 3 4 5 6
  localparam logic [41:0] W1 = {7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};  // 2 3 4 5 6 7
  localparam logic [41:0] W6 = {7'h78, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};  // 7 1 2 3 4 5
  localparam logic [41:0] WB = {6{7'h7F}};

  logic clk_50M = 1'b0;
  logic reset = 1'b0, reset_div = 1'b1, run = 1'b0;
  logic [41:0] hex_out;
  logic [2:0]  pos;
  logic        wrap;

  int n_cmp = 0, n_bad = 0;

  id_scroller #(.CLK_HZ(8), .STEP_HZ(2)) dut (
    .clk_50M  (clk_50M),
    .reset    (reset),
    .reset_div(reset_div),
    .run      (run),
    .hex_out  (hex_out),
    .pos      (pos),
    .wrap     (wrap)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [41:0] window(input int p, input bit blank);
    logic [27:0] idv;
    logic [41:0] w;
    logic [3:0]  nib;
    int d;
    idv = ID_V;
    w = '0;
    for (int k = 0; k < NH; k++) begin
      d = (p + NH - 1 - k) % ND;
      nib = 4'(idv >> (4 * d));
      w[7*k +: 7] = blank ? 7'h7F : SEG[nib];
    end
    return w;
  endfunction

  // Behavioural model: step counter, position, gap flag, and the window latched one cycle late.
  int          m_cnt = 0, m_pos = 0;
  bit          m_wrap = 0, m_gap = 0;
  logic [41:0] m_hex = '1;

  always @(posedge clk_50M or negedge reset) begin : model
    int  c, p;
    bit  t, w, g;
    if (!reset) begin
      m_cnt <= 0; m_pos <= 0; m_wrap <= 0; m_gap <= 0; m_hex <= '1;
    end else begin
      c = m_cnt; p = m_pos; g = m_gap; t = 0; w = 0;
      if (!reset_div) c = 0;
      else if (run) begin
        if (c == DIV - 1) begin c = 0; t = 1; end
        else c = c + 1;
      end
      if (t) begin
        if (g) g = 0;
        else if (p == ND - 1) begin
          p = 0; w = 1;
`ifdef ID_BLINK_EN
          g = 1;
`endif
        end else p = p + 1;
      end
      m_hex  <= window(m_pos, m_gap);
      m_cnt  <= c;
      m_pos  <= p;
      m_wrap <= w;
      m_gap  <= g;
    end
  end

  always @(negedge clk_50M) begin
    chk("pos",  64'(pos),     64'(m_pos));
    chk("wrap", 64'(wrap),    64'(m_wrap));
    chk("hex",  64'(hex_out), 64'(m_hex));
  end

  initial begin
    repeat (3) @(negedge clk_50M);
    chk("rst_hex", 64'(hex_out), 64'(WB));
    chk("rst_pos", 64'(pos), 64'd0);
    #1 reset = 1'b1;
    @(negedge clk_50M);
    chk("init_win", 64'(hex_out), 64'(W0));
    chk("init_wrap", 64'(wrap), 64'd0);
    #1 run = 1'b1;
    repeat (4) @(negedge clk_50M);
    chk("step1_pos", 64'(pos), 64'd1);
    @(negedge clk_50M);
    chk("step1_win", 64'(hex_out), 64'(W1));
    @(negedge clk_50M);                       // cnt = 2
    #1 run = 1'b0;
    repeat (10) @(negedge clk_50M);
    chk("pause_pos", 64'(pos), 64'd1);
    chk("pause_win", 64'(hex_out), 64'(W1));
    #1 run = 1'b1;
    @(negedge clk_50M);
    chk("resume_hold", 64'(pos), 64'd1);
    @(negedge clk_50M);
    chk("resume_tick", 64'(pos), 64'd2);
    repeat (3) @(negedge clk_50M);            // cnt = 3, tick pending
    #1 reset_div = 1'b0;
    @(negedge clk_50M);
    chk("rdiv_notick", 64'(pos), 64'd2);
    #1 reset_div = 1'b1;
    repeat (3) @(negedge clk_50M);
    chk("rdiv_hold", 64'(pos), 64'd2);
    @(negedge clk_50M);
    chk("rdiv_tick", 64'(pos), 64'd3);
    repeat (12) @(negedge clk_50M);
    chk("pos6", 64'(pos), 64'd6);
    @(negedge clk_50M);
    chk("win6", 64'(hex_out), 64'(W6));
    chk("pre_wrap", 64'(wrap), 64'd0);
    repeat (3) @(negedge clk_50M);
    chk("wrap_pulse", 64'(wrap), 64'd1);
    chk("wrap_pos", 64'(pos), 64'd0);
    @(negedge clk_50M);
    chk("wrap_end", 64'(wrap), 64'd0);
`ifdef ID_BLINK_EN
    chk("gap_win", 64'(hex_out), 64'(WB));
    repeat (4) @(negedge clk_50M);
    chk("gap_exit", 64'(hex_out), 64'(W0));
    chk("gap_pos", 64'(pos), 64'd0);
`else
    chk("wrap_win", 64'(hex_out), 64'(W0));
`endif

    for (int i = 0; i < 4000; i++) begin
      #1;
      run       = ($urandom_range(0, 99) < 85);
      reset_div = ($urandom_range(0, 99) >= 3);
      reset     = ($urandom_range(0, 399) != 0);
      @(negedge clk_50M);
    end

    #1 reset = 1'b1;
    @(negedge clk_50M);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
